// File: rtl/sample_framer.sv
// sample_framer: upstream byte feeder for the LVDS serializer.
// Buffers 16-bit I/Q sample pairs in a small FIFO and frames them into fixed
// length packets: SYNC_BYTE, sequence number, payload (I hi, I lo, Q hi, Q lo
// per sample) and, when SAMPLE_FRAMER_CSUM_EN is defined, a trailing XOR
// checksum over SEQ and payload. One byte advances per serializer request.
//
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-high reset
//   en              - enables sample capture and new packet starts
//   s_valid/s_i/s_q - sample pair input, no backpressure
//   dr              - serializer data request (current byte consumed)
//   data            - registered byte to serializer
//   busy            - registered, high when framer state is not IDLE
//   overflow        - sticky, a sample was dropped on a full FIFO
//   drop_cnt        - saturating count of dropped samples
//
// Optional feature macro: SAMPLE_FRAMER_CSUM_EN (adds the CSUM byte).
module sample_framer #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned PKT_SAMPLES = 4,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        s_valid,
    input  logic [15:0] s_i,
    input  logic [15:0] s_q,
    input  logic        dr,
    output logic [7:0]  data,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = 7;
    localparam logic [CW-1:0] PKT_CNT     = CW'(PKT_SAMPLES);
    localparam logic [CW-1:0] FULL_CNT    = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(PKT_SAMPLES - 1);

`ifdef SAMPLE_FRAMER_CSUM_EN
    typedef enum logic [2:0] {IDLE, SYNC, SEQ, PAYLOAD, CSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, SYNC, SEQ, PAYLOAD} state_t;
`endif

    state_t          state;
    logic [31:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [7:0]      seq;
    logic [1:0]      idx;
    logic [SW-1:0]   scnt;
`ifdef SAMPLE_FRAMER_CSUM_EN
    logic [7:0]      csum;
`endif

    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    logic [CW-1:0]   avail;
    logic            ready;
    logic            last_sample;
    logic [31:0]     head;
    logic [7:0]      next_hi;
    logic [7:0]      next_byte;

    // FIFO handshake; a pop frees the slot a same-cycle push on a full FIFO uses
    always_comb begin
        full        = (count == FULL_CNT);
        pop         = (state == PAYLOAD) && dr && (idx == 2'd3);
        push        = en && s_valid && (!full || pop);
        drop        = en && s_valid && full && !pop;
        // Samples leaving this cycle must not count toward the next packet
        avail       = count - CW'(pop);
        ready       = en && (avail >= PKT_CNT);
        last_sample = (scnt == LAST_SAMPLE);
        head        = mem[rd_ptr];
        next_hi     = mem[rd_ptr + AW'(1)][31:24];
        case (idx)
            2'd0:    next_byte = head[23:16];
            2'd1:    next_byte = head[15:8];
            default: next_byte = head[7:0];
        endcase
    end

    // Sample storage (no reset needed, validity tracked by count)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s_i, s_q};
    end

    // FIFO pointers, occupancy and overflow bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'h00;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Packet framing FSM; every transition is gated by a serializer request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            data  <= 8'h00;
            busy  <= 1'b0;
            seq   <= 8'h00;
            idx   <= 2'd0;
            scnt  <= '0;
`ifdef SAMPLE_FRAMER_CSUM_EN
            csum  <= 8'h00;
`endif
        end else if (dr) begin
            case (state)
                IDLE: begin
                    if (ready) begin
                        data  <= SYNC_BYTE;
                        state <= SYNC;
                        busy  <= 1'b1;
                    end else begin
                        data  <= 8'h00;
                    end
                end
                SYNC: begin
                    data  <= seq;
                    state <= SEQ;
`ifdef SAMPLE_FRAMER_CSUM_EN
                    csum  <= seq;
`endif
                end
                SEQ: begin
                    data  <= head[31:24];
                    idx   <= 2'd0;
                    scnt  <= '0;
                    state <= PAYLOAD;
`ifdef SAMPLE_FRAMER_CSUM_EN
                    csum  <= csum ^ head[31:24];
`endif
                end
                PAYLOAD: begin
                    if (idx != 2'd3) begin
                        data <= next_byte;
                        idx  <= idx + 2'd1;
`ifdef SAMPLE_FRAMER_CSUM_EN
                        csum <= csum ^ next_byte;
`endif
                    end else if (!last_sample) begin
                        // Head is popped this edge; next entry becomes head
                        data <= next_hi;
                        idx  <= 2'd0;
                        scnt <= scnt + SW'(1);
`ifdef SAMPLE_FRAMER_CSUM_EN
                        csum <= csum ^ next_hi;
`endif
                    end else begin
`ifdef SAMPLE_FRAMER_CSUM_EN
                        data  <= csum;
                        state <= CSUM;
`else
                        // End of packet: chain straight into the next SYNC
                        seq <= seq + 8'd1;
                        if (ready) begin
                            data  <= SYNC_BYTE;
                            state <= SYNC;
                        end else begin
                            data  <= 8'h00;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`endif
                    end
                end
`ifdef SAMPLE_FRAMER_CSUM_EN
                CSUM: begin
                    // End of packet: chain straight into the next SYNC
                    seq <= seq + 8'd1;
                    if (ready) begin
                        data  <= SYNC_BYTE;
                        state <= SYNC;
                    end else begin
                        data  <= 8'h00;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    data  <= 8'h00;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
